sram_axi_arbiter: RTL

Arbitrates the core's two SRAM-like memory ports (instruction fetch, read-only; data access, read/write) onto a single AXI3 master port, with at most one outstanding transaction per port. It sits between the IF/EX/MEM stages and the top-level AXI interface. It generates the `addr_ok`/`data_ok` handshakes that the MEM stage's `data_sram_data_ok` stall logic consumes.

---
 rtl/axi_arb_pkg.sv | 30 +++
 rtl/sram_axi_wr_channel.sv | 113 +++++++++++
 rtl/sram_axi_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the SRAM-to-AXI3 arbiter.
// Single-beat AXI transactions; one outstanding request per SRAM port.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_R
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_AW,
    W_B
  } wr_state_e;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'd0;
  localparam logic [2:0] AXI_PROT  = 3'd0;

  function automatic logic [2:0] axi_size(input logic [1:0] s);
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/sram_axi_wr_channel.sv
// Write FSM for the data port: AW and W issued together, each
// retiring on its own handshake, then wait for B.
module sram_axi_wr_channel
  import axi_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        block_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] wdata_i,
  output logic        accept_o,
  output logic        done_o,
  output logic        busy_o,
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awsize_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  wr_state_e   state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [3:0]  strb_q;
  logic [31:0] data_q;
  logic        aw_fin, w_fin;

  assign accept_o  = (state_q == W_IDLE) & req_i & ~block_i;
  assign awvalid_o = (state_q == W_AW) & ~aw_done_q;
  assign wvalid_o  = (state_q == W_AW) & ~w_done_q;
  assign bready_o  = (state_q == W_B);
  assign done_o    = bready_o & bvalid_i;
  assign busy_o    = (state_q != W_IDLE);

  assign aw_fin = aw_done_q | (awvalid_o & awready_i);
  assign w_fin  = w_done_q | (wvalid_o & wready_i);

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      W_IDLE: begin
        if (accept_o) begin
          state_d   = W_AW;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_AW: begin
        if (aw_fin & w_fin) begin
          state_d   = W_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      W_B: begin
        if (bvalid_i) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      id_q      <= 4'd0;
      addr_q    <= 32'd0;
      size_q    <= 3'd0;
      strb_q    <= 4'd0;
      data_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (accept_o) begin
        id_q   <= ID_DATA;
        addr_q <= addr_i;
        size_q <= axi_size(size_i);
        strb_q <= wstrb_i;
        data_q <= wdata_i;
      end
    end
  end

  assign awid_o   = id_q;
  assign awaddr_o = addr_q;
  assign awsize_o = size_q;
  assign wid_o    = id_q;
  assign wdata_o  = data_q;
  assign wstrb_o  = strb_q;
  assign wlast_o  = 1'b1;

endmodule

// File: rtl/sram_axi_arbiter.sv
// Merges the fetch and data SRAM-like ports onto one AXI3 master.
// Reads share one FSM (data first); data writes use their own channel.
module sram_axi_arbiter
  import axi_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_e   r_state_q, r_state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [3:0]  arid_q, arid_d;
  logic        inst_out_q, inst_out_d;
  logic        data_out_q, data_out_d;

  logic        wr_busy, wr_accept, wr_done, wr_block;
  logic        data_rd_cand, inst_rd_cand;
  logic        take_data, take_inst;
  logic        r_hs, rd_data_ok;
  logic        unused_in;

  // Data reads wait for the write channel to drain (read-after-write).
  assign data_rd_cand = data_sram_req & ~data_sram_wr
                      & ~data_out_q & ~wr_busy;
  assign inst_rd_cand = inst_sram_req & ~inst_out_q;

  assign take_data = (r_state_q == R_IDLE) & data_rd_cand;
  assign take_inst = (r_state_q == R_IDLE) & inst_rd_cand
                   & ~data_rd_cand;

  assign wr_block = data_out_q
                  | ((r_state_q != R_IDLE) & (arid_q == ID_DATA));

  assign r_hs       = (r_state_q == R_R) & rvalid;
  assign rd_data_ok = r_hs & rid[0];

  assign inst_sram_addr_ok = take_inst;
  assign data_sram_addr_ok = take_data | wr_accept;
  assign inst_sram_data_ok = r_hs & ~rid[0];
  assign data_sram_data_ok = rd_data_ok | wr_done;
  assign inst_sram_rdata   = rdata & {32{inst_sram_data_ok}};
  assign data_sram_rdata   = rdata & {32{rd_data_ok}};

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    arid_d    = arid_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (take_data) begin
          r_state_d = R_AR;
          araddr_d  = data_sram_addr;
          arsize_d  = axi_size(data_sram_size);
          arid_d    = ID_DATA;
        end else if (take_inst) begin
          r_state_d = R_AR;
          araddr_d  = inst_sram_addr;
          arsize_d  = axi_size(inst_sram_size);
          arid_d    = ID_INST;
        end
      end
      R_AR: begin
        if (arready) r_state_d = R_R;
      end
      R_R: begin
        if (rvalid) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    inst_out_d = inst_out_q;
    data_out_d = data_out_q;
    if (inst_sram_addr_ok) inst_out_d = 1'b1;
    else if (inst_sram_data_ok) inst_out_d = 1'b0;
    if (data_sram_addr_ok) data_out_d = 1'b1;
    else if (data_sram_data_ok) data_out_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q  <= R_IDLE;
      araddr_q   <= 32'd0;
      arsize_q   <= 3'd0;
      arid_q     <= 4'd0;
      inst_out_q <= 1'b0;
      data_out_q <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      araddr_q   <= araddr_d;
      arsize_q   <= arsize_d;
      arid_q     <= arid_d;
      inst_out_q <= inst_out_d;
      data_out_q <= data_out_d;
    end
  end

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = (r_state_q == R_AR);
  assign rready  = (r_state_q == R_R);

  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;

  // Single-beat, always-OKAY usage: these response fields carry nothing.
  assign unused_in = ^{rresp, rlast, rid[3:1], bid, bresp};

  sram_axi_wr_channel u_wr (
    .clk       (clk),
    .reset     (reset),
    .req_i     (data_sram_req & data_sram_wr),
    .block_i   (wr_block),
    .size_i    (data_sram_size),
    .addr_i    (data_sram_addr),
    .wstrb_i   (data_sram_wstrb),
    .wdata_i   (data_sram_wdata),
    .accept_o  (wr_accept),
    .done_o    (wr_done),
    .busy_o    (wr_busy),
    .awid_o    (awid),
    .awaddr_o  (awaddr),
    .awsize_o  (awsize),
    .awvalid_o (awvalid),
    .awready_i (awready),
    .wid_o     (wid),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb),
    .wlast_o   (wlast),
    .wvalid_o  (wvalid),
    .wready_i  (wready),
    .bvalid_i  (bvalid),
    .bready_o  (bready)
  );

endmodule
